// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the display arbiter: state encoding,
// timing defaults and the fixed-priority request encoder.
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DWELL = 2'b01,
    ST_HOLD  = 2'b10,
    ST_GAP   = 2'b11
  } state_t;

  localparam logic [15:0] DWELL_DEF    = 16'hBB8;
  localparam logic [15:0] MAX_HOLD_DEF = 16'h7530;

  // REQ[2] wins over REQ[1], which wins over REQ[0]; result is one-hot or zero.
  function automatic logic [2:0] prio_onehot(input logic [2:0] req);
    if (req[2])      return 3'b100;
    else if (req[1]) return 3'b010;
    else if (req[0]) return 3'b001;
    else             return 3'b000;
  endfunction

endpackage

// File: rtl/display_arbiter_timer.sv
// Grant-length timer: clears on a new grant, counts while granted,
// saturates at all-ones and flags the dwell and max-hold thresholds.
module display_arbiter_timer
  import display_arbiter_pkg::*;
#(
  parameter logic [15:0] DWELL    = DWELL_DEF,
  parameter logic [15:0] MAX_HOLD = MAX_HOLD_DEF,
  parameter bit          TO_EN    = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic dwell_done,
  output logic hold_expire
);

  logic [15:0] count;

  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != 16'hFFFF))
      count <= count + 16'd1;
  end

  assign dwell_done  = (count == (DWELL - 16'd1));
  // Without the timeout feature the expiry flag is permanently low.
  assign hold_expire = TO_EN && (count == (MAX_HOLD - 16'd1));

endmodule

// File: rtl/display_arbiter.sv
// Three-requester display arbiter with minimum dwell before preemption.
// Define DISPLAY_ARBITER_TIMEOUT_EN to bound grants and mask timed-out requesters.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter logic [15:0] DWELL    = DWELL_DEF,
  parameter logic [15:0] MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  output logic [2:0] GNT,
  output logic [7:0] LEDS,
  output logic       DISP,
  output logic       BUSY,
  output logic       TIMEOUT
);

  state_t      state, state_nxt;
  logic [2:0]  req_eff, gnt_nxt, higher;
  logic [7:0]  leds_nxt;
  logic        disp_nxt, granted, released, dwell_done, hold_expire, timeout_hit;

  assign granted     = (state == ST_DWELL) || (state == ST_HOLD);
  assign released    = ~|(REQ & GNT);
  assign timeout_hit = granted && hold_expire;
  assign higher      = {GNT[1] | GNT[0], GNT[0], 1'b0};

`ifdef DISPLAY_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  logic [2:0] mask;

  // A timed-out requester stays masked until it drops its REQ for a cycle.
  always_ff @(posedge CLK) begin
    if (RST)
      mask <= '0;
    else
      mask <= (mask & REQ) | (timeout_hit ? GNT : 3'b000);
  end

  assign req_eff = REQ & ~mask;
`else
  localparam bit TO_EN = 1'b0;
  assign req_eff = REQ;
`endif

  display_arbiter_timer #(
    .DWELL    (DWELL),
    .MAX_HOLD (MAX_HOLD),
    .TO_EN    (TO_EN)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .clr         ((state == ST_IDLE) && (|req_eff)),
    .en          (granted),
    .dwell_done  (dwell_done),
    .hold_expire (hold_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      GNT   <= '0;
      LEDS  <= '0;
      DISP  <= 1'b0;
    end else begin
      state <= state_nxt;
      GNT   <= gnt_nxt;
      LEDS  <= leds_nxt;
      DISP  <= disp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req_eff) state_nxt = ST_DWELL;
      ST_DWELL: begin
        if (released || timeout_hit) state_nxt = ST_GAP;
        else if (dwell_done)         state_nxt = ST_HOLD;
      end
      // Release, preemption and timeout all collapse into one Gap cycle.
      ST_HOLD:  if (released || timeout_hit || (|(req_eff & higher))) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt  = '0;
    leds_nxt = '0;
    disp_nxt = 1'b0;
    BUSY     = (state != ST_IDLE);
    TIMEOUT  = timeout_hit;
    if ((state == ST_IDLE) && (|req_eff)) begin
      gnt_nxt = prio_onehot(req_eff);
    end else if (granted && ((state_nxt == ST_DWELL) || (state_nxt == ST_HOLD))) begin
      gnt_nxt  = GNT;
      disp_nxt = 1'b1;
      case (GNT)
        3'b001:  leds_nxt = DATA0;
        3'b010:  leds_nxt = DATA1;
        3'b100:  leds_nxt = DATA2;
        default: leds_nxt = '0;
      endcase
    end
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter DWELL, default 16'hBB8: minimum grant length in CLK cycles before preemption is allowed.
REQ-002 Parameter MAX_HOLD, default 16'h7530: maximum grant length in CLK cycles when the timeout feature is compiled in; SHALL be greater than DWELL.
REQ-003 CLK  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 REQ  input  3  display requests; REQ[2] has highest priority and REQ[0] lowest; a requester holds its REQ high for as long as it wants the display.
REQ-006 DATA0, DATA1, DATA2  input  8 each  LED pattern of requesters 0, 1 and 2.
REQ-007 GNT  output  3  one-hot or zero grant, registered.
REQ-008 LEDS  output  8  displayed pattern, registered.
REQ-009 DISP  output  1  display enable, registered; high only while a grant is active.
REQ-010 BUSY  output  1  high in every state except Idle.
REQ-011 TIMEOUT  output  1  one-cycle pulse when a grant is revoked by timeout; SHALL be tied 0 without the timeout feature.

Function
REQ-012 The FSM SHALL have four states: Idle, Dwell, Hold and Gap.
REQ-013 Idle: GNT=0, LEDS=0, DISP=0; any unmasked REQ SHALL select the highest-priority one, giving GNT one-hot and state Dwell on the next edge.
REQ-014 Grant latency SHALL be exactly 1 cycle from REQ sampled high in Idle.
REQ-015 While granted (Dwell or Hold), LEDS SHALL equal the granted requester's DATA with 1-cycle latency, and DISP SHALL be 1.
REQ-016 A 16-bit timer SHALL clear to 0 on the Idle->Dwell transition, increment every cycle in Dwell and Hold, and saturate at 16'hFFFF.
REQ-017 Dwell: when the timer equals DWELL-1, the next state SHALL be Hold; higher-priority requests SHALL be ignored in Dwell.
REQ-018 Dwell or Hold: deassertion of the granted REQ SHALL cause Gap on the next edge, regardless of the timer.
REQ-019 Hold: an unmasked REQ of higher priority than the granted one SHALL cause Gap on the next edge (preemption).
REQ-020 Release and preemption in the same cycle SHALL produce a single Gap.
REQ-021 Gap SHALL last exactly one cycle with GNT=0, LEDS=0 and DISP=0, then return to Idle; Idle arbitrates in the following cycle, so re-grant comes 2 cycles after leaving Hold.
REQ-022 A lower-priority REQ arriving during a grant SHALL wait until Idle; pending REQs SHALL NOT be latched.

Reset
REQ-023 On RST high at a CLK edge: state=Idle, GNT=0, LEDS=0, DISP=0, BUSY=0, TIMEOUT=0, timer=0, all mask bits=0.
REQ-024 RST during any grant SHALL drop GNT at that same edge, with no Gap cycle.

Configuration
REQ-025 Macro DISPLAY_ARBITER_TIMEOUT_EN SHALL compile in the timeout feature.
REQ-026 With DISPLAY_ARBITER_TIMEOUT_EN defined:
- timer equal to MAX_HOLD-1 in Dwell or Hold SHALL force Gap, pulse TIMEOUT, and set the granted requester's mask bit.
- a set mask bit SHALL be cleared in the first cycle its REQ is sampled low.
- a masked REQ SHALL be ignored for arbitration and preemption.
REQ-027 Without DISPLAY_ARBITER_TIMEOUT_EN: no mask register; TIMEOUT is constant 0; grants are unbounded.

Structure
REQ-028 A shared package display_arbiter_pkg SHALL hold the state encoding (Idle=2'b00, Dwell=2'b01, Hold=2'b10, Gap=2'b11), the DWELL and MAX_HOLD defaults, and the 3-bit priority-encoder function.
REQ-029 The timer (clear, enable, saturate, compare outputs) SHALL be the single sub-module display_arbiter_timer.

Verification
REQ-030 RST released, REQ=3'b001, DATA0=8'hA5 -> GNT=3'b001 one cycle later, LEDS=8'hA5 and DISP=1 on the following cycle.
REQ-031 REQ=3'b011 in the same cycle from Idle -> GNT=3'b010; REQ[0] is ignored until GNT returns to 0.
REQ-032 Grant REQ[0], assert REQ[2] at timer=100 with DWELL=16'hBB8 -> GNT stays 3'b001 until timer=16'hBB7, then 1 Gap cycle, Idle, then GNT=3'b100.
REQ-033 Drop the granted REQ in Dwell at timer=5 -> Gap next edge with GNT=0 and DISP=0, then Idle with BUSY=0.
REQ-034 With DISPLAY_ARBITER_TIMEOUT_EN, MAX_HOLD=16'h0100, REQ[1] held high -> TIMEOUT pulses at timer=16'h00FF; no re-grant of requester 1 until its REQ is low for 1 cycle and then high again.
REQ-035 Assert RST during Hold -> GNT=0 and LEDS=0 at that same edge; an existing REQ is re-granted 1 cycle after RST is released.
